// File: rtl/lut_neuron_pkg.sv
// Shared types and derived constants for the LUT neuron loader.
// Default geometry: 256 entries x 2 bits, loaded as 32-bit config words.
package lut_neuron_pkg;

  localparam int IN_BITS_D  = 8;
  localparam int OUT_BITS_D = 2;
  localparam int WORD_W_D   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2,
    ERR   = 2'd3
  } state_e;

  // Counter width, never below one bit so a one-word table still has a counter.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int EPW    = WORD_W_D / OUT_BITS_D;
  localparam int NWORDS = (2 ** IN_BITS_D) / EPW;
  localparam int CNT_W  = cnt_width(NWORDS);

endpackage

// File: rtl/lut_neuron_table.sv
// Truth-table storage: distributed RAM with a word-wide write port
// (EPW entries per write) and a registered single-entry read port.
module lut_neuron_table #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 2,
  parameter int EPW      = 16,
  parameter int AW       = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [EPW*OUT_BITS-1:0] wdata,
  input  logic                    re,
  input  logic [IN_BITS-1:0]      raddr,
  output logic [OUT_BITS-1:0]     rdata
);

  localparam int DEPTH = 2 ** IN_BITS;

  (* ram_style = "distributed" *) logic [OUT_BITS-1:0] mem_r [DEPTH];

  // Word write: entry j of word k lands at k*EPW + j; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int j = 0; j < EPW; j++) begin
        mem_r[IN_BITS'(int'(waddr) * EPW + j)] <= wdata[j*OUT_BITS +: OUT_BITS];
      end
    end
  end

  // Read register holds its value when no lookup is requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= {OUT_BITS{1'b0}};
    end else if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/lut_neuron_loader.sv
// Runtime loader for a LogicNets LUT neuron: streams a truth table in over a
// valid/ready port, checks framing, then serves lookups with 1-cycle latency.
module lut_neuron_loader
  import lut_neuron_pkg::*;
#(
  parameter int IN_BITS  = IN_BITS_D,
  parameter int OUT_BITS = OUT_BITS_D,
  parameter int WORD_W   = WORD_W_D
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [WORD_W-1:0]   cfg_data,
  input  logic                cfg_last,
  output logic                load_done,
  output logic                load_err,
  input  logic                in_valid,
  input  logic [IN_BITS-1:0]  M0,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] M1
);

  localparam int EPW_L = WORD_W / OUT_BITS;
  localparam int NW_L  = (2 ** IN_BITS) / EPW_L;
  localparam int CW_L  = cnt_width(NW_L);
  localparam logic [CW_L-1:0] LAST_IDX = CW_L'(NW_L - 1);

  state_e          state_r, state_nxt_s;
  logic [CW_L-1:0] wcnt_r, wcnt_nxt_s;
  logic            cfg_ready_r, load_done_r, load_err_r, out_valid_r;
  logic            hs_s, we_s, re_s;

  // Next state, word counter and table write enable; cfg_start overrides all.
  always_comb begin
    hs_s        = cfg_valid & cfg_ready_r;
    state_nxt_s = state_r;
    wcnt_nxt_s  = wcnt_r;
    we_s        = 1'b0;
    if (cfg_start) begin
      state_nxt_s = LOAD;
      wcnt_nxt_s  = {CW_L{1'b0}};
    end else begin
      case (state_r)
        LOAD: begin
          if (hs_s) begin
            if (wcnt_r == LAST_IDX) begin
              if (cfg_last) begin
                we_s        = 1'b1;
                state_nxt_s = READY;
              end else begin
                state_nxt_s = ERR;
              end
            end else if (cfg_last) begin
              state_nxt_s = ERR;
            end else begin
              we_s       = 1'b1;
              wcnt_nxt_s = wcnt_r + CW_L'(1);
            end
          end else begin
            state_nxt_s = state_r;
          end
        end
        default: state_nxt_s = state_r;
      endcase
    end
    re_s = in_valid & (state_r == READY) & ~cfg_start;
  end

  // Status flags are registered from the next state so they track it exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      wcnt_r      <= {CW_L{1'b0}};
      cfg_ready_r <= 1'b0;
      load_done_r <= 1'b0;
      load_err_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      wcnt_r      <= wcnt_nxt_s;
      cfg_ready_r <= (state_nxt_s == LOAD);
      load_done_r <= (state_nxt_s == READY);
      load_err_r  <= (state_nxt_s == ERR);
      out_valid_r <= re_s;
    end
  end

  lut_neuron_table #(
    .IN_BITS  (IN_BITS),
    .OUT_BITS (OUT_BITS),
    .EPW      (EPW_L),
    .AW       (CW_L)
  ) u_table (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we_s),
    .waddr (wcnt_r),
    .wdata (cfg_data),
    .re    (re_s),
    .raddr (M0),
    .rdata (M1)
  );

  assign cfg_ready = cfg_ready_r;
  assign load_done = load_done_r;
  assign load_err  = load_err_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_lut_neuron_loader.sv
// Randomised scoreboard bench for lut_neuron_loader: a behavioural table model
// predicts lookups, a negedge monitor pops and compares every out_valid pulse.
module tb_lut_neuron_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cfg_start = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_last = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] cfg_data = 32'd0;
  logic [7:0]  M0 = 8'd0;
  logic        cfg_ready, load_done, load_err, out_valid;
  logic [1:0]  M1;

  int         tests = 0;
  int         fails = 0;
  logic [1:0] ref_tbl [256];
  bit         ref_ready = 1'b0;
  logic [1:0] expq [$];
  int         run_len = 0;
  int         max_run = 0;
  int         oc;

  lut_neuron_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .cfg_last  (cfg_last),
    .load_done (load_done),
    .load_err  (load_err),
    .in_valid  (in_valid),
    .M0        (M0),
    .out_valid (out_valid),
    .M1        (M1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every out_valid pulse must match the oldest expected lookup.
  always @(negedge clk) begin
    logic [1:0] e;
    if (rst_n === 1'b1) begin
      if (out_valid === 1'b1) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (expq.size() == 0) begin
          check("spurious out_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          e = expq.pop_front();
          check("lookup M1", {30'd0, M1}, {30'd0, e});
        end
      end else begin
        run_len = 0;
      end
    end else begin
      run_len = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pat_word(input int k);
    logic [31:0] w;
    for (int j = 0; j < 16; j++) w[j*2 +: 2] = 2'((k + j) % 4);
    return w;
  endfunction

  task automatic do_start();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    ref_ready = 1'b0;
    check("cfg_ready after start", cfg_ready, 1'b1);
    check("load_err after start", load_err, 1'b0);
    check("load_done after start", load_done, 1'b0);
  endtask

  // Sends up to nwords words; last_at = index carrying cfg_last (-1 = none).
  // outcome: 0 still loading, 1 table valid, 2 framing error.
  task automatic send_frame(input int nwords, input int last_at, input int maxgap,
                            input bit rnd, output int outcome);
    logic [31:0] w;
    outcome = 0;
    for (int k = 0; k < nwords; k++) begin
      w = rnd ? $urandom : pat_word(k);
      repeat ($urandom_range(maxgap, 0)) begin
        check("cfg_ready held in load", cfg_ready, 1'b1);
        tick();
      end
      cfg_valid = 1'b1;
      cfg_data  = w;
      cfg_last  = (k == last_at);
      check("cfg_ready held in load", cfg_ready, 1'b1);
      tick();
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
      if (k == 15 && k != last_at) begin outcome = 2; break; end
      if (k == last_at && k != 15) begin outcome = 2; break; end
      for (int j = 0; j < 16; j++) ref_tbl[k*16 + j] = w[j*2 +: 2];
      if (k == 15) begin outcome = 1; break; end
    end
    ref_ready = (outcome == 1);
    if (outcome != 0) begin
      check("load_done after frame", load_done, outcome == 1);
      check("load_err after frame", load_err, outcome == 2);
      check("cfg_ready after frame", cfg_ready, 1'b0);
    end
  endtask

  task automatic lookup(input logic [7:0] a, input bit cs);
    in_valid  = 1'b1;
    M0        = a;
    cfg_start = cs;
    if (ref_ready && !cs) expq.push_back(ref_tbl[a]);
    if (cs) ref_ready = 1'b0;
    tick();
    in_valid  = 1'b0;
    cfg_start = 1'b0;
  endtask

  task automatic drain(input string name);
    tick();
    tick();
    check(name, expq.size(), 32'd0);
    expq.delete();
  endtask

  task automatic sweep();
    max_run = 0;
    for (int a = 0; a < 256; a++) lookup(8'(a), 1'b0);
    drain("sweep drained");
    check("sweep consecutive pulses", max_run, 32'd256);
  endtask

  initial begin
    // 1: reset state and lookups ignored in IDLE
    #2 rst_n = 1'b0;
    #1;
    check("reset cfg_ready", cfg_ready, 1'b0);
    check("reset load_done", load_done, 1'b0);
    check("reset load_err", load_err, 1'b0);
    check("reset out_valid", out_valid, 1'b0);
    check("reset M1", M1, 2'b00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    lookup(8'h10, 1'b0);
    check("out_valid in idle", out_valid, 1'b0);
    drain("idle drained");

    // 2: full pattern load, spot lookup and sweep
    do_start();
    send_frame(16, 15, 0, 1'b0, oc);
    in_valid = 1'b1;
    M0 = 8'hC3;
    expq.push_back(2'b11);
    tick();
    in_valid = 1'b0;
    check("C3 latency out_valid", out_valid, 1'b1);
    drain("C3 drained");
    sweep();

    // 1b: asynchronous reset with a lookup in flight, then mid-load
    lookup(8'h07, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("async reset out_valid", out_valid, 1'b0);
    check("async reset M1", M1, 2'b00);
    check("async reset load_done", load_done, 1'b0);
    expq.delete();
    ref_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    do_start();
    send_frame(6, -1, 1, 1'b1, oc);
    #2 rst_n = 1'b0;
    #1;
    check("reset mid-load cfg_ready", cfg_ready, 1'b0);
    tick();
    rst_n = 1'b1;
    lookup(8'h05, 1'b0);
    check("load_done after partial", load_done, 1'b0);
    drain("partial drained");

    // 3: gaps between words; same pattern then random contents
    do_start();
    send_frame(16, 15, 3, 1'b0, oc);
    sweep();
    do_start();
    send_frame(16, 15, 2, 1'b1, oc);
    sweep();

    // start coincident with a handshake discards the word
    do_start();
    send_frame(3, -1, 0, 1'b1, oc);
    cfg_valid = 1'b1;
    cfg_data  = $urandom;
    cfg_start = 1'b1;
    tick();
    cfg_valid = 1'b0;
    cfg_start = 1'b0;
    check("cfg_ready after start+word", cfg_ready, 1'b1);
    send_frame(16, 15, 0, 1'b1, oc);
    sweep();

    // 4: early last
    do_start();
    send_frame(6, 5, 0, 1'b1, oc);
    for (int i = 0; i < 4; i++) lookup(8'($urandom), 1'b0);
    drain("err lookups drained");
    do_start();

    // 5: missing last, then good reload
    send_frame(16, -1, 0, 1'b1, oc);
    do_start();
    send_frame(16, 15, 1, 1'b1, oc);
    sweep();

    // 6: sweep interrupted by cfg_start
    max_run = 0;
    for (int a = 0; a < 256; a++) lookup(8'(a), a == 100);
    drain("interrupted sweep drained");
    check("pulses before start", max_run, 32'd100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
